// File: rtl/ysyx_23060187_mem_arbiter.sv
// IFU/LSU arbiter sharing one memory request/response port, one transaction at a time.
// Define YSYX_23060187_ARB_RR_EN for round-robin; otherwise LSU has fixed priority.
module ysyx_23060187_mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_rsp_valid,
    input  logic        ifu_rsp_ready,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_rsp_valid,
    input  logic        lsu_rsp_ready,
    output logic [31:0] lsu_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RSP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        gnt;
    logic [31:0] rdata;
    logic        idle;
    logic        pick_lsu;
    logic        accept;
    logic        rsp_hs;

    assign idle   = (state == IDLE);
    assign accept = idle & (ifu_req_valid | lsu_req_valid);

`ifdef YSYX_23060187_ARB_RR_EN
    // last = 1 means LSU won the previous grant, so IFU wins the next tie
    logic last;

    assign pick_lsu = lsu_req_valid & (~ifu_req_valid | ~last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b0;
        end else if (accept) begin
            last <= pick_lsu;
        end
    end
`else
    assign pick_lsu = lsu_req_valid;
`endif

    assign ifu_req_ready = idle & ifu_req_valid & ~pick_lsu;
    assign lsu_req_ready = idle & pick_lsu;

    assign mem_req_valid = (state == REQ);
    assign mem_rsp_ready = (state == RSP);
    assign ifu_rsp_valid = (state == DONE) & ~gnt;
    assign lsu_rsp_valid = (state == DONE) & gnt;
    assign ifu_rdata     = rdata;
    assign lsu_rdata     = rdata;
    assign busy          = ~idle;

    assign rsp_hs = gnt ? lsu_rsp_ready : ifu_rsp_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)        state_nxt = REQ;
            REQ:  if (mem_req_ready) state_nxt = RSP;
            RSP:  if (mem_rsp_valid) state_nxt = DONE;
            DONE: if (rsp_hs)        state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wen   <= 1'b0;
            mem_wmask <= 4'd0;
            rdata     <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                gnt <= pick_lsu;
                if (pick_lsu) begin
                    mem_addr  <= lsu_addr;
                    mem_wdata <= lsu_wdata;
                    mem_wen   <= lsu_wen;
                    mem_wmask <= lsu_wmask;
                end else begin
                    mem_addr  <= ifu_addr;
                    mem_wdata <= 32'd0;
                    mem_wen   <= 1'b0;
                    mem_wmask <= 4'd0;
                end
            end
            if ((state == RSP) && mem_rsp_valid) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060187_mem_arbiter.sv
// Directed self-checking bench for ysyx_23060187_mem_arbiter.
// Honours YSYX_23060187_ARB_RR_EN to pick the expected grant order.
module tb_ysyx_23060187_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    ysyx_23060187_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_rsp_valid(lsu_rsp_valid),
        .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " hs"}, {26'd0, ifu_req_ready, lsu_req_ready, ifu_rsp_valid,
                           lsu_rsp_valid, mem_req_valid, mem_rsp_ready}, 32'd0);
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    endtask

    // IFU fetch with memory ready immediately; checks each cycle T..T+4
    task automatic ifu_txn(input logic [31:0] a, input logic [31:0] d);
        ifu_req_valid = 1'b1; ifu_addr = a; ifu_rsp_ready = 1'b1;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rdata = d;
        #1;
        chk("ifu T ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd2);
        chk("ifu T busy", {31'd0, busy}, 32'd0);
        tick();
        ifu_req_valid = 1'b0; mem_rsp_valid = 1'b1;
        chk("ifu T1 reqv", {31'd0, mem_req_valid}, 32'd1);
        chk("ifu T1 addr", mem_addr, a);
        chk("ifu T1 wen/mask", {27'd0, mem_wen, mem_wmask}, 32'd0);
        chk("ifu T1 busy", {30'd0, busy, ifu_req_ready}, 32'd2);
        tick();
        chk("ifu T2 rspr", {30'd0, mem_rsp_ready, mem_req_valid}, 32'd2);
        tick();
        mem_rsp_valid = 1'b0;
        chk("ifu T3 rspv", {29'd0, ifu_rsp_valid, lsu_rsp_valid, busy}, 32'd5);
        chk("ifu T3 rdata", ifu_rdata, d);
        tick();
        chk("ifu T4 idle", {30'd0, busy, ifu_rsp_valid}, 32'd0);
    endtask

    initial begin
        logic exp_lsu;
        rst = 1'b1;
        ifu_req_valid = 0; ifu_addr = 0; ifu_rsp_ready = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0;
        lsu_wmask = 0; lsu_rsp_ready = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
        tick(); tick();
        chk_quiet("reset");
        chk("reset addr", mem_addr, 32'd0);
        chk("reset rdata", ifu_rdata, 32'd0);
        rst = 1'b0;
        tick();

        ifu_txn(32'h8000_0000, 32'h0000_0413);

        // spurious downstream response while idle
        mem_rsp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        #1;
        chk_quiet("spurious");
        tick();
        chk_quiet("spurious+1");
        chk("spurious rdata", lsu_rdata, 32'h0000_0413);
        mem_rsp_valid = 1'b0;

        // LSU store with a 5-cycle mem_req_ready stall
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1000;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF; mem_req_ready = 1'b0;
        #1;
        chk("st ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd1);
        tick();
        lsu_req_valid = 1'b0; lsu_addr = 32'h1111_1111;
        lsu_wdata = 32'h2222_2222; lsu_wmask = 4'h3; lsu_wen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("st stall reqv", {31'd0, mem_req_valid}, 32'd1);
            chk("st stall addr", mem_addr, 32'h8000_1000);
            chk("st stall wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("st stall wen/mask", {27'd0, mem_wen, mem_wmask}, 32'h1F);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("st rsp state", {30'd0, mem_rsp_ready, mem_req_valid}, 32'd2);
        chk("st no early rsp", {31'd0, lsu_rsp_valid}, 32'd0);
        mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_rsp_valid = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;

        // LSU holds off its response for 3 cycles with IFU waiting
        for (int i = 0; i < 3; i++) begin
            chk("done stall rspv", {30'd0, lsu_rsp_valid, ifu_rsp_valid}, 32'd2);
            chk("done stall rdata", lsu_rdata, 32'h1234_5678);
            chk("done stall gate", {29'd0, ifu_req_ready, mem_req_valid, mem_rsp_ready}, 32'd0);
            chk("done stall wen", {31'd0, mem_wen}, 32'd1);
            tick();
        end
        lsu_rsp_ready = 1'b1;
        tick();
        chk("after st idle", {29'd0, busy, lsu_rsp_valid, ifu_req_ready}, 32'd1);
        ifu_req_valid = 1'b0;
        #1;

        // arbitration from a fresh reset, both masters requesting continuously
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100; ifu_rsp_ready = 1'b1;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b1;
        lsu_wdata = 32'h5; lsu_wmask = 4'h1; lsu_rsp_ready = 1'b1;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'hAA;
        #1;
        for (int g = 0; g < 4; g++) begin
`ifdef YSYX_23060187_ARB_RR_EN
            exp_lsu = ((g % 2) == 0);
`else
            exp_lsu = 1'b1;
`endif
            chk("arb ready", {30'd0, ifu_req_ready, lsu_req_ready}, {30'd0, ~exp_lsu, exp_lsu});
            tick();
            chk("arb addr", mem_addr, exp_lsu ? 32'h8000_2000 : 32'h8000_0100);
            chk("arb wen", {31'd0, mem_wen}, {31'd0, exp_lsu});
            tick(); tick();
            chk("arb rspv", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, {30'd0, ~exp_lsu, exp_lsu});
            tick();
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_rsp_valid = 1'b0;
        lsu_wen = 1'b0;
        tick();

        // reset while waiting for the downstream response
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200;
        tick();
        ifu_req_valid = 1'b0;
        tick();
        chk("pre-rst rsp", {31'd0, mem_rsp_ready}, 32'd1);
        rst = 1'b1;
        #1;
        chk_quiet("mid rst");
        chk("mid rst addr", mem_addr, 32'd0);
        tick();
        rst = 1'b0;
        chk_quiet("post rst");
        ifu_txn(32'h8000_0300, 32'h0010_0093);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
